gen_mux_wb_n: RTL and testbench

GEN_MUX_WB_N -- requirements
Module: gen_mux_wb_n

---
 rtl/gen_mux_wb_pkg.sv | 19 +
 rtl/gen_mux_wb_n_addr_decode.sv | 38 +++
 rtl/gen_mux_wb_n.sv | 178 +++++++++++++++++
 tb/tb_gen_mux_wb_n.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_mux_wb_pkg.sv
// Shared types and helpers for the Wishbone 1-to-N address-decoding multiplexer.
// Holds the arbitration FSM state encoding and the timeout counter sizing rule.
package gen_mux_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_e;

    // The counter must be able to hold TIMEOUT_CYCLES itself; a disabled
    // timeout (0) still needs a 1-bit register to keep the datapath legal.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/gen_mux_wb_n_addr_decode.sv
// Address decoder: compares the master address against every slave prefix/mask
// pair and reports whether any slave matches plus the lowest matching index.
module wb_addr_decode
    import gen_mux_wb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0]            adr_i,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base_i,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] msk_i,
    output logic                             hit_o,
    output logic [IDX_WIDTH-1:0]             idx_o
);

    logic [NUM_SLAVES-1:0] match;

    generate
        genvar gi;
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = ((adr_i ^ base_i[gi*ADDR_WIDTH +: ADDR_WIDTH])
                                & msk_i[gi*ADDR_WIDTH +: ADDR_WIDTH]) == '0;
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_o = |match;
        idx_o = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                idx_o = IDX_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/gen_mux_wb_n.sv
// Wishbone 1-master to N-slave multiplexer with per-beat address decode,
// decode-miss error response and a per-transaction response timeout.
module gen_mux_wb_n
    import gen_mux_wb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [ADDR_WIDTH-1:0]             wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]             wbm_dat_i,
    output logic [DATA_WIDTH-1:0]             wbm_dat_o,
    input  logic                              wbm_we_i,
    input  logic [SELECT_WIDTH-1:0]           wbm_sel_i,
    input  logic                              wbm_stb_i,
    input  logic                              wbm_cyc_i,
    output logic                              wbm_ack_o,
    output logic                              wbm_err_o,
    output logic                              wbm_rty_o,

    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [NUM_SLAVES-1:0]              wbs_we_o,
    output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]              wbs_stb_o,
    output logic [NUM_SLAVES-1:0]              wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]              wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]              wbs_err_i,
    input  logic [NUM_SLAVES-1:0]              wbs_rty_i,

    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk,

    output logic                              err_decode_o,
    output logic                              err_timeout_o,
    output logic [$clog2(NUM_SLAVES)-1:0]     err_slave_o
);

    localparam int unsigned     IDX_W     = $clog2(NUM_SLAVES);
    localparam int unsigned     CNT_W     = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0]  TMO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]    err_slave_q, err_slave_d;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                req;
    logic                g_ack, g_err, g_rty, g_term;
    logic                tmo_hit;
    logic                slv_en;
    logic [DATA_WIDTH-1:0] slv_dat [NUM_SLAVES];

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_decode (
        .adr_i  (wbm_adr_i),
        .base_i (wbs_addr),
        .msk_i  (wbs_addr_msk),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    generate
        genvar gi;
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign wbs_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]       = wbm_adr_i;
            assign wbs_dat_o[gi*DATA_WIDTH +: DATA_WIDTH]       = wbm_dat_i;
            assign wbs_sel_o[gi*SELECT_WIDTH +: SELECT_WIDTH]   = wbm_sel_i;
            assign wbs_cyc_o[gi] = slv_en && (grant_q == IDX_W'(gi)) && wbm_cyc_i;
            assign wbs_stb_o[gi] = slv_en && (grant_q == IDX_W'(gi)) && wbm_stb_i;
            assign wbs_we_o[gi]  = slv_en && (grant_q == IDX_W'(gi)) && wbm_we_i;
            assign slv_dat[gi]   = wbs_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign req    = wbm_cyc_i & wbm_stb_i;
    assign g_ack  = wbs_ack_i[grant_q];
    assign g_err  = wbs_err_i[grant_q];
    assign g_rty  = wbs_rty_i[grant_q];
    assign g_term = g_ack | g_err | g_rty;

    // Expiry is the ACTIVE cycle whose count, including itself, reaches the
    // limit; a same-cycle termination or an abort always takes precedence.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q == ACTIVE) && wbm_cyc_i
                     && !g_term && (({1'b0, tmo_cnt_q} + (CNT_W + 1)'(1)) == TMO_LIMIT);

    assign slv_en      = (state_q == ACTIVE) && !rst && !tmo_hit;
    assign err_slave_o = (tmo_hit && !rst) ? grant_q : err_slave_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            tmo_cnt_q   <= '0;
            err_slave_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_slave_q <= err_slave_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_slave_d   = err_slave_q;
        wbm_ack_o     = 1'b0;
        wbm_err_o     = 1'b0;
        wbm_rty_o     = 1'b0;
        wbm_dat_o     = '0;
        err_decode_o  = 1'b0;
        err_timeout_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (dec_hit) begin
                        grant_d   = dec_idx;
                        tmo_cnt_d = '0;
                        state_d   = ACTIVE;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end

            ACTIVE: begin
                wbm_dat_o = slv_dat[grant_q];
                wbm_ack_o = g_ack;
                wbm_err_o = g_err | tmo_hit;
                wbm_rty_o = g_rty;
                if (!wbm_cyc_i || g_term) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    err_timeout_o = 1'b1;
                    err_slave_d   = grant_q;
                    state_d       = IDLE;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            ERROR: begin
                wbm_err_o    = 1'b1;
                err_decode_o = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset abandons whatever is in flight without answering the master.
        if (rst) begin
            wbm_ack_o     = 1'b0;
            wbm_err_o     = 1'b0;
            wbm_rty_o     = 1'b0;
            wbm_dat_o     = '0;
            err_decode_o  = 1'b0;
            err_timeout_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_gen_mux_wb_n.sv
// Self-checking bench for gen_mux_wb_n: directed vector table, hand-written
// abort/reset sequences and randomized transactions against a behavioural model.
module tb_gen_mux_wb_n;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_SILENT = 3;
    localparam int O_ACK = 0, O_ERR = 1, O_RTY = 2, O_TMO = 3, O_DEC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_wdat, m_rdat;
    logic            m_we, m_stb, m_cyc;
    logic [SW-1:0]   m_sel;
    logic            m_ack, m_err, m_rty;
    logic [N*AW-1:0] s_adr;
    logic [N*DW-1:0] s_wdat, s_rdat;
    logic [N-1:0]    s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
    logic [N*SW-1:0] s_sel;
    logic [N*AW-1:0] cfg_addr, cfg_msk;
    logic            err_dec, err_tmo;
    logic [1:0]      err_slv;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_err_slv;

    logic [31:0] base_tab [N];
    logic [31:0] msk_tab  [N];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          kind;
        int          delay;
        logic [31:0] rdata;
        int          spur_slave;
        int          spur_cyc;
        int          exp_slave;
        int          exp_out;
        int          exp_t;
    } vec_t;

    vec_t tab [10];

    always #5 clk = ~clk;

    gen_mux_wb_n #(
        .NUM_SLAVES     (N),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SELECT_WIDTH   (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wbm_adr_i     (m_adr),
        .wbm_dat_i     (m_wdat),
        .wbm_dat_o     (m_rdat),
        .wbm_we_i      (m_we),
        .wbm_sel_i     (m_sel),
        .wbm_stb_i     (m_stb),
        .wbm_cyc_i     (m_cyc),
        .wbm_ack_o     (m_ack),
        .wbm_err_o     (m_err),
        .wbm_rty_o     (m_rty),
        .wbs_adr_o     (s_adr),
        .wbs_dat_o     (s_wdat),
        .wbs_dat_i     (s_rdat),
        .wbs_we_o      (s_we),
        .wbs_sel_o     (s_sel),
        .wbs_stb_o     (s_stb),
        .wbs_cyc_o     (s_cyc),
        .wbs_ack_i     (s_ack),
        .wbs_err_i     (s_err),
        .wbs_rty_i     (s_rty),
        .wbs_addr      (cfg_addr),
        .wbs_addr_msk  (cfg_msk),
        .err_decode_o  (err_dec),
        .err_timeout_o (err_tmo),
        .err_slave_o   (err_slv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode: lowest slave whose masked prefix equals the address.
    function automatic int model_slave(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if (((a ^ base_tab[k]) & msk_tab[k]) == 32'h0) return k;
        end
        return -1;
    endfunction

    function automatic vec_t mk_rand();
        vec_t v;
        v.addr         = $urandom;
        v.addr[31:28]  = 4'($urandom_range(0, 9));
        v.we           = 1'($urandom_range(0, 1));
        v.wdata        = $urandom;
        v.kind         = int'($urandom_range(0, 3));
        v.delay        = int'($urandom_range(1, 10));
        v.rdata        = $urandom;
        v.exp_slave    = model_slave(v.addr);
        if (v.exp_slave < 0) begin
            v.exp_out = O_DEC;
            v.exp_t   = 1;
        end else if (v.kind != K_SILENT && v.delay <= TMO) begin
            v.exp_out = v.kind;
            v.exp_t   = v.delay;
        end else begin
            v.exp_out = O_TMO;
            v.exp_t   = TMO;
        end
        v.spur_slave = -1;
        v.spur_cyc   = -1;
        if (v.exp_slave >= 0 && v.exp_t > 1 && $urandom_range(0, 1) == 1) begin
            v.spur_cyc   = int'($urandom_range(1, v.exp_t - 1));
            v.spur_slave = (v.exp_slave + int'($urandom_range(1, 3))) % N;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [N-1:0] exp_stb;
        logic         exp_ack, exp_err, exp_rty, exp_dec, exp_tmo;
        logic [31:0]  exp_dat;
        @(negedge clk);
        m_adr = v.addr; m_we = v.we; m_wdat = v.wdata; m_sel = '1;
        m_cyc = 1'b1;   m_stb = 1'b1;
        for (int j = 0; j < N; j++)
            s_rdat[j*DW +: DW] = (j == v.exp_slave) ? v.rdata : (v.rdata ^ 32'h5A5A_0000 ^ 32'(j + 1));
        for (int c = 0; c <= v.exp_t; c++) begin
            if (c > 0) @(negedge clk);
            s_ack = '0; s_err = '0; s_rty = '0;
            if (v.exp_slave >= 0 && v.kind != K_SILENT && c == v.delay) begin
                case (v.kind)
                    K_ACK:   s_ack[v.exp_slave] = 1'b1;
                    K_ERR:   s_err[v.exp_slave] = 1'b1;
                    default: s_rty[v.exp_slave] = 1'b1;
                endcase
            end
            if (v.spur_slave >= 0 && c == v.spur_cyc) begin
                s_ack[v.spur_slave] = 1'b1;
                s_err[v.spur_slave] = 1'b1;
            end
            #1;
            exp_stb = '0; exp_ack = 0; exp_err = 0; exp_rty = 0; exp_dec = 0; exp_tmo = 0; exp_dat = '0;
            if (v.exp_slave < 0) begin
                if (c == 1) begin exp_err = 1; exp_dec = 1; end
            end else if (c > 0) begin
                exp_dat = v.rdata;
                if (c == v.exp_t && v.exp_out == O_TMO) begin
                    exp_err = 1; exp_tmo = 1; exp_err_slv = 2'(v.exp_slave);
                end else begin
                    exp_stb = 4'b0001 << v.exp_slave;
                    if (c == v.exp_t) begin
                        exp_ack = (v.exp_out == O_ACK);
                        exp_err = (v.exp_out == O_ERR);
                        exp_rty = (v.exp_out == O_RTY);
                    end
                end
            end
            if (c == 0) begin
                check($sformatf("v%0d.bcast", id),
                      {s_adr[3*AW +: AW], s_wdat[2*DW +: DW]}, {v.addr, v.wdata});
            end
            check($sformatf("v%0d.c%0d.stb", id, c), 64'(s_stb), 64'(exp_stb));
            check($sformatf("v%0d.c%0d.cyc", id, c), 64'(s_cyc), 64'(exp_stb));
            check($sformatf("v%0d.c%0d.we",  id, c), 64'(s_we),  64'(v.we ? exp_stb : 4'b0));
            check($sformatf("v%0d.c%0d.resp", id, c), {m_ack, m_err, m_rty}, {exp_ack, exp_err, exp_rty});
            check($sformatf("v%0d.c%0d.dat", id, c), 64'(m_rdat), 64'(exp_dat));
            check($sformatf("v%0d.c%0d.errflags", id, c), {err_dec, err_tmo}, {exp_dec, exp_tmo});
            check($sformatf("v%0d.c%0d.err_slave", id, c), 64'(err_slv), 64'(exp_err_slv));
        end
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_err = '0; s_rty = '0;
        #1;
        check($sformatf("v%0d.idle", id), {s_stb, s_cyc, m_ack, m_err, m_rty, err_dec, err_tmo},
              {4'b0, 4'b0, 5'b0});
        $display("txn %0d adr=%08h we=%0d slave=%0d out=%0d t=%0d", id, v.addr, v.we,
                 v.exp_slave, v.exp_out, v.exp_t);
    endtask

    initial begin
        base_tab[0] = 32'h0000_0000; msk_tab[0] = 32'hF000_0000;
        base_tab[1] = 32'h1000_0000; msk_tab[1] = 32'hF000_0000;
        base_tab[2] = 32'h2000_0000; msk_tab[2] = 32'hF000_0000;
        base_tab[3] = 32'h1000_0000; msk_tab[3] = 32'h8000_0000;
        for (int k = 0; k < N; k++) begin
            cfg_addr[k*AW +: AW] = base_tab[k];
            cfg_msk[k*AW +: AW]  = msk_tab[k];
        end

        //           addr          we wdata         kind      dly rdata         spS spC  exS exOut  exT
        tab[0] = '{32'h2000_0010, 0, 32'h0,        K_ACK,    3, 32'hDEAD_BEEF, -1, -1,  2, O_ACK, 3};
        tab[1] = '{32'h1000_0000, 1, 32'h1111_2222, K_ACK,   1, 32'h0BAD_F00D, -1, -1,  1, O_ACK, 1};
        tab[2] = '{32'hF000_0000, 0, 32'h0,        K_ACK,    1, 32'h0,         -1, -1, -1, O_DEC, 1};
        tab[3] = '{32'h3000_0004, 0, 32'h0,        K_SILENT, 1, 32'h1234_0000, -1, -1,  3, O_TMO, 8};
        tab[4] = '{32'h3000_0008, 1, 32'hCAFE_0001, K_ACK,   8, 32'h5555_AAAA,  0,  2,  3, O_ACK, 8};
        tab[5] = '{32'h0000_1234, 1, 32'h0102_0304, K_ERR,   2, 32'h7777_0000, -1, -1,  0, O_ERR, 2};
        tab[6] = '{32'h2FFF_FFFC, 0, 32'h0,        K_RTY,    5, 32'h89AB_CDEF,  1,  3,  2, O_RTY, 5};
        tab[7] = '{32'h4000_0000, 0, 32'h0,        K_ACK,    9, 32'h2468_ACE0,  2,  4,  3, O_TMO, 8};
        tab[8] = '{32'h8000_0000, 1, 32'hFFFF_FFFF, K_ACK,   1, 32'h0,         -1, -1, -1, O_DEC, 1};
        tab[9] = '{32'h1234_5678, 0, 32'h0,        K_ACK,    2, 32'h0F0F_F0F0,  3,  1,  1, O_ACK, 2};

        rst = 1'b1; m_adr = '0; m_wdat = '0; m_we = 0; m_sel = '0; m_stb = 0; m_cyc = 0;
        s_rdat = '0; s_ack = '0; s_err = '0; s_rty = '0;
        exp_err_slv = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.slave_ctl", {s_cyc, s_stb, s_we}, 12'h0);
        check("reset.master", {m_ack, m_err, m_rty, err_dec, err_tmo}, 5'h0);
        check("reset.dat", 64'(m_rdat), 64'h0);
        check("reset.err_slave", 64'(err_slv), 64'h0);

        for (int i = 0; i < 10; i++) run_vec(tab[i], i);

        // Abort: master drops cyc while ACTIVE; slave cyc follows at once.
        @(negedge clk);
        m_adr = 32'h2000_0000; m_we = 0; m_cyc = 1; m_stb = 1;
        @(negedge clk); #1;
        check("abort.stb_before", 64'(s_stb), 64'h4);
        @(negedge clk);
        m_cyc = 0; m_stb = 0; #1;
        check("abort.cyc_drop", {s_cyc, s_stb}, 8'h0);
        check("abort.no_err", {m_ack, m_err, m_rty}, 3'h0);
        @(negedge clk);
        m_adr = 32'h0000_0040; m_cyc = 1; m_stb = 1; #1;
        check("abort.idle_after", 64'(s_stb), 64'h0);
        @(negedge clk);
        s_ack = 4'b0001; #1;
        check("abort.next_stb", 64'(s_stb), 64'h1);
        check("abort.next_ack", 64'(m_ack), 64'h1);
        @(negedge clk);
        m_cyc = 0; m_stb = 0; s_ack = '0;
        $display("txn abort sequence done");

        // Reset in the middle of an ACTIVE transfer.
        @(negedge clk);
        m_adr = 32'h2000_0000; m_cyc = 1; m_stb = 1;
        @(negedge clk); #1;
        check("rst.stb_before", 64'(s_stb), 64'h4);
        @(negedge clk);
        rst = 1; s_ack = 4'b0100; #1;
        check("rst.cyc_gated", {s_cyc, s_stb, s_we}, 12'h0);
        check("rst.no_resp", {m_ack, m_err, m_rty, err_dec, err_tmo}, 5'h0);
        @(negedge clk);
        rst = 0; s_ack = '0; exp_err_slv = 2'd0; #1;
        check("rst.idle_next", 64'(s_stb), 64'h0);
        check("rst.err_slave_clr", 64'(err_slv), 64'(exp_err_slv));
        check("rst.no_err_next", 64'(m_err), 64'h0);
        @(negedge clk);
        s_ack = 4'b0100; #1;
        check("rst.restart_stb", 64'(s_stb), 64'h4);
        check("rst.restart_ack", 64'(m_ack), 64'h1);
        @(negedge clk);
        m_cyc = 0; m_stb = 0; s_ack = '0;
        $display("txn reset sequence done");

        for (int i = 0; i < 40; i++) run_vec(mk_rand(), 100 + i);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
